// File: rtl/sobel_compute_engine.sv
// Two-stage pipelined horizontal Sobel (Gx) kernel on a 3x3 window of unsigned pixels.
// Stage 1 forms the three column differences. Stage 2 takes their weighted sum and sign-extends it.
module sobel_compute_engine #(
    parameter int PIXEL_W = 8,
    parameter int GRAD_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     valid_in,
    input  logic [9*PIXEL_W-1:0]     pixels_3x3,
    output logic                     valid_out,
    output logic signed [GRAD_W-1:0] gradient_x,
    output logic                     busy
);

    localparam int DIFF_W = PIXEL_W + 1;

    function automatic logic signed [DIFF_W-1:0] col_diff(
        input logic [PIXEL_W-1:0] right,
        input logic [PIXEL_W-1:0] left
    );
        return $signed({1'b0, right}) - $signed({1'b0, left});
    endfunction

    function automatic logic signed [GRAD_W-1:0] sext(input logic signed [DIFF_W-1:0] d);
        return {{(GRAD_W-DIFF_W){d[DIFF_W-1]}}, d};
    endfunction

    logic [PIXEL_W-1:0]        p00_s, p02_s, p10_s, p12_s, p20_s, p22_s;
    logic signed [DIFF_W-1:0]  d0_s, d1_s, d2_s;
    logic signed [DIFF_W-1:0]  d0_r, d1_r, d2_r;
    logic                      v1_r;
    logic signed [GRAD_W-1:0]  sum_s;
    logic signed [GRAD_W-1:0]  grad_r;
    logic                      valid_out_r;
    logic                      unused_centre_s;

    // Row-major window: p00 occupies the most significant byte.
    assign p00_s = pixels_3x3[8*PIXEL_W +: PIXEL_W];
    assign p02_s = pixels_3x3[6*PIXEL_W +: PIXEL_W];
    assign p10_s = pixels_3x3[5*PIXEL_W +: PIXEL_W];
    assign p12_s = pixels_3x3[3*PIXEL_W +: PIXEL_W];
    assign p20_s = pixels_3x3[2*PIXEL_W +: PIXEL_W];
    assign p22_s = pixels_3x3[0*PIXEL_W +: PIXEL_W];

    // The centre column carries zero weight in Gx.
    assign unused_centre_s = ^{pixels_3x3[7*PIXEL_W +: PIXEL_W],
                               pixels_3x3[4*PIXEL_W +: PIXEL_W],
                               pixels_3x3[1*PIXEL_W +: PIXEL_W]};

    // Column differences and the weighted stage-2 sum.
    always_comb begin
        d0_s  = col_diff(p02_s, p00_s);
        d1_s  = col_diff(p12_s, p10_s);
        d2_s  = col_diff(p22_s, p20_s);
        sum_s = sext(d0_r) + (sext(d1_r) <<< 1'b1) + sext(d2_r);
    end

    // Stage 1 register. It holds its contents while enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            d0_r <= '0;
            d1_r <= '0;
            d2_r <= '0;
            v1_r <= 1'b0;
        end else if (enable) begin
            d0_r <= d0_s;
            d1_r <= d1_s;
            d2_r <= d2_s;
            v1_r <= valid_in;
        end else begin
            d0_r <= d0_r;
            d1_r <= d1_r;
            d2_r <= d2_r;
            v1_r <= v1_r;
        end
    end

    // Stage 2 register. The gradient updates only when a valid entry advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            grad_r      <= '0;
            valid_out_r <= 1'b0;
        end else if (enable) begin
            valid_out_r <= v1_r;
            if (v1_r) begin
                grad_r <= sum_s;
            end else begin
                grad_r <= grad_r;
            end
        end else begin
            valid_out_r <= 1'b0;
            grad_r      <= grad_r;
        end
    end

    assign valid_out  = valid_out_r;
    assign gradient_x = grad_r;
    assign busy       = v1_r | valid_out_r;

endmodule

// File: tb/tb_sobel_compute_engine.sv
// Scoreboard bench for sobel_compute_engine: directed windows followed by randomized traffic.
// It checks them against a plain-arithmetic Gx reference model.
module tb_sobel_compute_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               valid_in;
    logic [71:0]        pixels_3x3;
    logic               valid_out;
    logic signed [15:0] gradient_x;
    logic               busy;

    int tests = 0;
    int fails = 0;

    // Each accepted window puts its expected result in exp_q.
    // stamp_q holds the enabled-edge count at which that window was accepted.
    int                 exp_q[$];
    int                 stamp_q[$];
    int                 en_edges  = 0;
    int                 last_grad = 0;
    bit                 check_on  = 1'b0;

    sobel_compute_engine dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .valid_in   (valid_in),
        .pixels_3x3 (pixels_3x3),
        .valid_out  (valid_out),
        .gradient_x (gradient_x),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference Gx from the kernel definition, using plain integers.
    function automatic int gx_model(input logic [71:0] w);
        int p[9];
        for (int i = 0; i < 9; i++) p[i] = int'(w[71-8*i -: 8]);
        return (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic vi, input logic [71:0] px);
        rst = r; enable = en; valid_in = vi; pixels_3x3 = px;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            stamp_q.delete();
            last_grad = 0;
            check_on  = 1'b1;
        end else if (en) begin
            en_edges++;
            if (vi) begin
                exp_q.push_back(gx_model(px));
                stamp_q.push_back(en_edges);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 72'h0);
    endtask

    // Monitor: the front entry is due after exactly one more enabled edge following its acceptance.
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            if (check_on) begin
                exp_v = (exp_q.size() > 0) && (en_edges - stamp_q[0] == 1);
                check("busy", int'(busy), int'(exp_q.size() != 0));
                check("valid_out", int'(valid_out), int'(exp_v));
                if (exp_v) begin
                    last_grad = exp_q.pop_front();
                    void'(stamp_q.pop_front());
                end
                check("gradient_x", int'(gradient_x), last_grad);
            end
        end
    end

    localparam logic [71:0] W_EDGE   = 72'h0000FF0000FF0000FF;
    localparam logic [71:0] W_SMOOTH = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    localparam logic [71:0] W_REV    = 72'hFF0000FF0000FF0000;
    localparam logic [71:0] W_REV2   = 72'hFFFF00FFFF00FFFF00;
    localparam logic [71:0] W_FLAT   = {9{8'd128}};

    function automatic logic [71:0] rand_window();
        logic [71:0] w;
        for (int i = 0; i < 9; i++) begin
            case ($urandom_range(0, 3))
                0:       w[8*i +: 8] = 8'd0;
                1:       w[8*i +: 8] = 8'd255;
                default: w[8*i +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; valid_in = 1'b0; pixels_3x3 = 72'h0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 72'h0);
        idle(4);

        // Single windows separated by idle gaps.
        step(1'b0, 1'b1, 1'b1, W_EDGE);   idle(4);
        step(1'b0, 1'b1, 1'b1, W_SMOOTH); idle(4);
        step(1'b0, 1'b1, 1'b1, W_REV);    idle(4);
        step(1'b0, 1'b1, 1'b1, W_REV2);   idle(4);
        step(1'b0, 1'b1, 1'b1, W_FLAT);   idle(4);

        // Back-to-back windows.
        step(1'b0, 1'b1, 1'b1, W_EDGE);
        step(1'b0, 1'b1, 1'b1, W_SMOOTH);
        step(1'b0, 1'b1, 1'b1, W_REV);
        idle(4);

        // Three-cycle stall after acceptance; windows offered during the stall must be dropped.
        step(1'b0, 1'b1, 1'b1, W_EDGE);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, W_REV2);
        idle(4);

        // Reset with windows in flight.
        step(1'b0, 1'b1, 1'b1, W_REV);
        step(1'b0, 1'b1, 1'b1, W_SMOOTH);
        step(1'b1, 1'b1, 1'b1, W_EDGE);
        // A window presented as reset deasserts is accepted.
        step(1'b0, 1'b1, 1'b1, W_REV2);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 70), rand_window());
        end
        idle(5);

        check("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
